// File: rtl/nubus_pkg.sv
// Shared types for the NuBus memory arbiter: FSM states, grant encodings and
// the NuBus size/address to byte-enable decode.
package nubus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SLV_ACC  = 2'd1,
    CPU_ACC  = 2'd2,
    SLV_WAIT = 2'd3
  } arb_state_e;

  localparam logic GRANT_SLV = 1'b0;
  localparam logic GRANT_CPU = 1'b1;

  // tm0n=1 selects word/halfword by addr[1:0]; tm0n=0 is a single byte lane.
  function automatic logic [3:0] nubus_be(input logic tm0n, input logic [1:0] a);
    logic [3:0] be;
    if (!tm0n) begin
      be = 4'b0001 << a;
    end else begin
      case (a)
        2'b01:   be = 4'b0011;
        2'b11:   be = 4'b1100;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

endpackage

// File: rtl/nubus_arb_timer.sv
// Slave-pending timeout counter: clears when idle, counts while enabled and
// strobes on the increment that reaches TIMEOUT_CYCLES.
module nubus_arb_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [7:0] LastCount = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = en && !clr && (cnt_q == LastCount);

endmodule

// File: rtl/nubus_mem_arbiter.sv
// Shares the card memory port between the NuBus slave path and the local CPU.
// Define NUBUS_ARB_CPU_LOCK_EN to add the cpu_lock input (CPU may hold the port).
module nubus_mem_arbiter
  import nubus_pkg::*;
#(
  parameter int unsigned MEM_AW         = 22,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              nub_clkn,
  input  logic              reset,
  input  logic              slv_myslotcy,
  input  logic [31:0]       slv_addr,
  input  logic              slv_tm1n,
  input  logic              slv_tm0n,
  input  logic [31:0]       slv_wdata,
  output logic [31:0]       slv_rdata,
  output logic              slv_ready,
  output logic              slv_timeout,
`ifdef NUBUS_ARB_CPU_LOCK_EN
  input  logic              cpu_lock,
`endif
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [3:0]        cpu_be,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_done
);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       slv_abort_q, slv_abort_d;

  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       slv_rdata_q, slv_rdata_d;
  logic              slv_ready_q, slv_ready_d;
  logic              slv_timeout_q, slv_timeout_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic              cpu_done_q, cpu_done_d;

  logic slv_req, cpu_req_eff, lock_cpu;
  logic grant_slv, grant_cpu;
  logic timer_en, timer_hit, timeout_fire;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{slv_addr[31:MEM_AW+2], cpu_addr[31:MEM_AW+2], cpu_addr[1:0]};

  // A timed-out slave stays ignored until it ends its cycle.
  assign slv_req     = slv_myslotcy && !slv_abort_q;
  // cpu_req is still high in the cycle cpu_done is presented.
  assign cpu_req_eff = cpu_req && !cpu_done_q;

`ifdef NUBUS_ARB_CPU_LOCK_EN
  assign lock_cpu = cpu_lock && (last_grant_q == GRANT_CPU);
`else
  assign lock_cpu = 1'b0;
`endif

  assign timer_en     = slv_myslotcy && !slv_abort_q && (state_q != SLV_WAIT);
  assign timeout_fire = timer_hit && !((state_q == SLV_ACC) && mem_done);

  assign grant_slv = (state_q == IDLE) && !timeout_fire && slv_req && !lock_cpu &&
                     (!cpu_req_eff || (last_grant_q == GRANT_CPU));
  assign grant_cpu = (state_q == IDLE) && !timeout_fire && cpu_req_eff && !grant_slv;

  nubus_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk  (nub_clkn),
    .reset(reset),
    .clr  (!slv_myslotcy),
    .en   (timer_en),
    .hit  (timer_hit)
  );

  always_ff @(posedge nub_clkn or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (timeout_fire)   state_d = SLV_WAIT;
        else if (grant_slv) state_d = SLV_ACC;
        else if (grant_cpu) state_d = CPU_ACC;
      end
      SLV_ACC: begin
        if (mem_done || timeout_fire) state_d = SLV_WAIT;
      end
      CPU_ACC: begin
        if (mem_done) state_d = IDLE;
      end
      SLV_WAIT: begin
        // An abandoned access may still be outstanding at memory.
        if (!slv_myslotcy && (!mem_valid_q || mem_done)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_valid_d   = mem_valid_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    slv_rdata_d   = slv_rdata_q;
    slv_ready_d   = 1'b0;
    slv_timeout_d = timeout_fire;
    cpu_rdata_d   = cpu_rdata_q;
    cpu_done_d    = 1'b0;
    last_grant_d  = last_grant_q;
    slv_abort_d   = slv_abort_q;

    if (!slv_myslotcy)     slv_abort_d = 1'b0;
    else if (timeout_fire) slv_abort_d = 1'b1;

    if (grant_slv) begin
      mem_valid_d  = 1'b1;
      mem_we_d     = ~slv_tm1n;
      mem_addr_d   = slv_addr[MEM_AW+1:2];
      mem_be_d     = nubus_be(slv_tm0n, slv_addr[1:0]);
      mem_wdata_d  = slv_wdata;
      last_grant_d = GRANT_SLV;
    end else if (grant_cpu) begin
      mem_valid_d  = 1'b1;
      mem_we_d     = cpu_we;
      mem_addr_d   = cpu_addr[MEM_AW+1:2];
      mem_be_d     = cpu_be;
      mem_wdata_d  = cpu_wdata;
      last_grant_d = GRANT_CPU;
    end

    if (mem_done && (state_q != IDLE)) begin
      mem_valid_d = 1'b0;
      if (state_q == SLV_ACC) begin
        slv_rdata_d = mem_rdata;
        slv_ready_d = slv_myslotcy;
      end else if (state_q == CPU_ACC) begin
        cpu_rdata_d = mem_rdata;
        cpu_done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge nub_clkn or posedge reset) begin
    if (reset) begin
      mem_valid_q   <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_be_q      <= 4'd0;
      mem_wdata_q   <= 32'd0;
      slv_rdata_q   <= 32'd0;
      slv_ready_q   <= 1'b0;
      slv_timeout_q <= 1'b0;
      cpu_rdata_q   <= 32'd0;
      cpu_done_q    <= 1'b0;
      last_grant_q  <= GRANT_CPU;
      slv_abort_q   <= 1'b0;
    end else begin
      mem_valid_q   <= mem_valid_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
      slv_rdata_q   <= slv_rdata_d;
      slv_ready_q   <= slv_ready_d;
      slv_timeout_q <= slv_timeout_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_done_q    <= cpu_done_d;
      last_grant_q  <= last_grant_d;
      slv_abort_q   <= slv_abort_d;
    end
  end

  assign mem_valid   = mem_valid_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;
  assign slv_rdata   = slv_rdata_q;
  assign slv_ready   = slv_ready_q;
  assign slv_timeout = slv_timeout_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_done    = cpu_done_q;

endmodule

// File: tb/tb_nubus_mem_arbiter.sv
// Directed bench for nubus_mem_arbiter (TIMEOUT_CYCLES=8); the cpu_lock
// sequence is included only when NUBUS_ARB_CPU_LOCK_EN is defined.
module tb_nubus_mem_arbiter;

  logic        nub_clkn = 1'b0;
  logic        reset;
  logic        slv_myslotcy;
  logic [31:0] slv_addr;
  logic        slv_tm1n;
  logic        slv_tm0n;
  logic [31:0] slv_wdata;
  logic [31:0] slv_rdata;
  logic        slv_ready;
  logic        slv_timeout;
`ifdef NUBUS_ARB_CPU_LOCK_EN
  logic        cpu_lock;
`endif
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        mem_valid;
  logic        mem_we;
  logic [21:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;

  int checks   = 0;
  int failures = 0;

  always #5 nub_clkn = ~nub_clkn;

  nubus_mem_arbiter #(
    .MEM_AW        (22),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .nub_clkn    (nub_clkn),
    .reset       (reset),
    .slv_myslotcy(slv_myslotcy),
    .slv_addr    (slv_addr),
    .slv_tm1n    (slv_tm1n),
    .slv_tm0n    (slv_tm0n),
    .slv_wdata   (slv_wdata),
    .slv_rdata   (slv_rdata),
    .slv_ready   (slv_ready),
    .slv_timeout (slv_timeout),
`ifdef NUBUS_ARB_CPU_LOCK_EN
    .cpu_lock    (cpu_lock),
`endif
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_be      (cpu_be),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_done    (cpu_done),
    .mem_valid   (mem_valid),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_done    (mem_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge nub_clkn);
    #1;
  endtask

  // Full slave access; extra = cycles mem_done is held off after mem_valid rises.
  task automatic slv_txn(input logic [31:0] a, input logic tm1, input logic tm0,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input logic [3:0] ebe, input logic [31:0] eaddr, input int extra);
    slv_myslotcy = 1'b1;
    slv_addr     = a;
    slv_tm1n     = tm1;
    slv_tm0n     = tm0;
    slv_wdata    = wd;
    step();
    chk("slv_mem_valid", {31'd0, mem_valid}, 32'd1);
    chk("slv_mem_addr", {10'd0, mem_addr}, eaddr);
    chk("slv_mem_be", {28'd0, mem_be}, {28'd0, ebe});
    chk("slv_mem_we", {31'd0, mem_we}, {31'd0, ~tm1});
    if (!tm1) chk("slv_mem_wdata", mem_wdata, wd);
    repeat (extra) begin
      step();
      chk("slv_valid_held", {31'd0, mem_valid}, 32'd1);
      chk("slv_no_early_ready", {31'd0, slv_ready}, 32'd0);
    end
    mem_done  = 1'b1;
    mem_rdata = rd;
    step();
    mem_done = 1'b0;
    chk("slv_ready", {31'd0, slv_ready}, 32'd1);
    chk("slv_valid_drop", {31'd0, mem_valid}, 32'd0);
    if (tm1) chk("slv_rdata", slv_rdata, rd);
    step();
    chk("slv_ready_pulse", {31'd0, slv_ready}, 32'd0);
    slv_myslotcy = 1'b0;
    step();
  endtask

  initial begin
    reset        = 1'b1;
    slv_myslotcy = 1'b0;
    slv_addr     = 32'd0;
    slv_tm1n     = 1'b1;
    slv_tm0n     = 1'b1;
    slv_wdata    = 32'd0;
`ifdef NUBUS_ARB_CPU_LOCK_EN
    cpu_lock     = 1'b0;
`endif
    cpu_req      = 1'b0;
    cpu_we       = 1'b0;
    cpu_addr     = 32'd0;
    cpu_be       = 4'd0;
    cpu_wdata    = 32'd0;
    mem_rdata    = 32'd0;
    mem_done     = 1'b0;
    #1;
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_slv_ready", {31'd0, slv_ready}, 32'd0);
    chk("rst_slv_timeout", {31'd0, slv_timeout}, 32'd0);
    chk("rst_cpu_done", {31'd0, cpu_done}, 32'd0);
    chk("rst_mem_addr", {10'd0, mem_addr}, 32'd0);
    step();
    reset = 1'b0;
    step();

    // Word read, byte write, halfword lanes
    slv_txn(32'h0000_0010, 1'b1, 1'b1, 32'd0, 32'hA5A5_1234, 4'b1111, 32'h4, 2);
    slv_txn(32'h0000_0102, 1'b0, 1'b0, 32'h1122_3344, 32'd0, 4'b0100, 32'h40, 0);
    slv_txn(32'h0000_0023, 1'b1, 1'b1, 32'd0, 32'h0BAD_F00D, 4'b1100, 32'h8, 0);
    slv_txn(32'h0040_0005, 1'b1, 1'b1, 32'd0, 32'h7777_0001, 4'b0011, 32'h10_0001, 1);

    // Tie after reset: slave first; then a fresh tie goes to the CPU
    reset = 1'b1;
    #3;
    reset = 1'b0;
    step();
    slv_myslotcy = 1'b1;
    slv_addr     = 32'h40;
    slv_tm1n     = 1'b1;
    slv_tm0n     = 1'b1;
    cpu_req      = 1'b1;
    cpu_we       = 1'b1;
    cpu_addr     = 32'h80;
    cpu_be       = 4'hF;
    cpu_wdata    = 32'hDEAD_BEEF;
    step();
    chk("tie1_slave_we", {31'd0, mem_we}, 32'd0);
    chk("tie1_slave_addr", {10'd0, mem_addr}, 32'h10);
    mem_done  = 1'b1;
    mem_rdata = 32'h0000_0042;
    step();
    mem_done = 1'b0;
    chk("tie1_slave_ready", {31'd0, slv_ready}, 32'd1);
    slv_myslotcy = 1'b0;
    step();
    slv_myslotcy = 1'b1;
    slv_addr     = 32'h44;
    step();
    chk("tie2_cpu_valid", {31'd0, mem_valid}, 32'd1);
    chk("tie2_cpu_we", {31'd0, mem_we}, 32'd1);
    chk("tie2_cpu_addr", {10'd0, mem_addr}, 32'h20);
    chk("tie2_cpu_wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    chk("tie2_cpu_done", {31'd0, cpu_done}, 32'd1);
    cpu_req = 1'b0;
    step();
    chk("tie2_done_pulse", {31'd0, cpu_done}, 32'd0);
    chk("tie2_slave_next", {31'd0, mem_valid}, 32'd1);
    chk("tie2_slave_addr", {10'd0, mem_addr}, 32'h11);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    chk("tie2_slave_ready", {31'd0, slv_ready}, 32'd1);
    slv_myslotcy = 1'b0;
    step();

    // Timeout with mem_done withheld
    slv_myslotcy = 1'b1;
    slv_addr     = 32'h100;
    step();
    chk("to_grant", {31'd0, mem_valid}, 32'd1);
    chk("to_addr", {10'd0, mem_addr}, 32'h40);
    repeat (6) step();
    chk("to_not_yet", {31'd0, slv_timeout}, 32'd0);
    step();
    chk("to_pulse", {31'd0, slv_timeout}, 32'd1);
    chk("to_valid_held", {31'd0, mem_valid}, 32'd1);
    chk("to_no_ready", {31'd0, slv_ready}, 32'd0);
    step();
    chk("to_pulse_width", {31'd0, slv_timeout}, 32'd0);
    mem_done  = 1'b1;
    mem_rdata = 32'hFFFF_0000;
    step();
    mem_done = 1'b0;
    chk("to_late_valid_drop", {31'd0, mem_valid}, 32'd0);
    chk("to_late_no_ready", {31'd0, slv_ready}, 32'd0);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h200;
    cpu_be   = 4'b0011;
    step();
    chk("to_wait_holds", {31'd0, mem_valid}, 32'd0);
    slv_myslotcy = 1'b0;
    step();
    chk("to_idle_no_grant_yet", {31'd0, mem_valid}, 32'd0);
    step();
    chk("to_cpu_after_valid", {31'd0, mem_valid}, 32'd1);
    chk("to_cpu_after_addr", {10'd0, mem_addr}, 32'h80);
    chk("to_cpu_after_be", {28'd0, mem_be}, 32'h3);

    // Async reset in the middle of CPU_ACC
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mid_addr", {10'd0, mem_addr}, 32'd0);
    chk("rst_mid_be", {28'd0, mem_be}, 32'd0);
    #2;
    reset = 1'b0;
    step();
    chk("post_rst_grant", {31'd0, mem_valid}, 32'd1);
    mem_done  = 1'b1;
    mem_rdata = 32'h5A5A_0F0F;
    step();
    mem_done = 1'b0;
    chk("post_rst_done", {31'd0, cpu_done}, 32'd1);
    chk("post_rst_rdata", cpu_rdata, 32'h5A5A_0F0F);
    chk("post_rst_valid_drop", {31'd0, mem_valid}, 32'd0);
    cpu_req = 1'b0;
    step();
    chk("post_rst_done_pulse", {31'd0, cpu_done}, 32'd0);

    // mem_done on the same edge the timeout would fire
    slv_myslotcy = 1'b1;
    slv_addr     = 32'h300;
    step();
    chk("race_grant", {31'd0, mem_valid}, 32'd1);
    repeat (6) step();
    mem_done  = 1'b1;
    mem_rdata = 32'h1357_9BDF;
    step();
    mem_done = 1'b0;
    chk("race_ready", {31'd0, slv_ready}, 32'd1);
    chk("race_no_timeout", {31'd0, slv_timeout}, 32'd0);
    chk("race_rdata", slv_rdata, 32'h1357_9BDF);
    step();
    chk("race_no_late_timeout", {31'd0, slv_timeout}, 32'd0);
    slv_myslotcy = 1'b0;
    step();

`ifdef NUBUS_ARB_CPU_LOCK_EN
    // CPU holds the port while locked; slave served after unlock
    cpu_lock  = 1'b1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h400;
    cpu_be    = 4'hF;
    cpu_wdata = 32'h1;
    step();
    chk("lock_cpu1_we", {31'd0, mem_we}, 32'd1);
    mem_done = 1'b1;
    step();
    mem_done     = 1'b0;
    slv_myslotcy = 1'b1;
    slv_addr     = 32'h500;
    step();
    chk("lock_no_slave", {31'd0, mem_valid}, 32'd0);
    step();
    chk("lock_cpu2_we", {31'd0, mem_we}, 32'd1);
    chk("lock_cpu2_addr", {10'd0, mem_addr}, 32'h100);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    step();
    step();
    chk("lock_cpu3_we", {31'd0, mem_we}, 32'd1);
    cpu_lock = 1'b0;
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    cpu_req  = 1'b0;
    step();
    chk("unlock_slave_valid", {31'd0, mem_valid}, 32'd1);
    chk("unlock_slave_we", {31'd0, mem_we}, 32'd0);
    chk("unlock_slave_addr", {10'd0, mem_addr}, 32'h140);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    chk("unlock_slave_ready", {31'd0, slv_ready}, 32'd1);
    slv_myslotcy = 1'b0;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
